// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver.
// Sticky overflow on dropped bytes, one-cycle underflow pulse on empty pops.
module uart_rx_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_count,
   output logic          o_overflow,
   input  logic          i_clr_ovf,
   output logic          o_underflow
);

   localparam int unsigned PW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          empty;
   logic          full;
   logic          pop_ok;
   logic          push_ok;
   logic          ovf_set;

   assign wr_idx = wr_ptr[AW-1:0];
   assign rd_idx = rd_ptr[AW-1:0];

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pop on a full FIFO frees the slot the coincident push lands in.
   assign pop_ok  = i_pop && !empty;
   assign push_ok = i_push && (!full || pop_ok);
   assign ovf_set = i_push && full && !pop_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Storage carries no reset; empty masks stale contents on the read port.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_idx] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_underflow <= i_pop && empty;
         if (ovf_set)        o_overflow <= 1'b1;
         else if (i_clr_ovf) o_overflow <= 1'b0;
      end
   end

   assign o_empty = empty;
   assign o_full  = full;
   assign o_count = wr_ptr - rd_ptr;
   assign o_rdata = empty ? '0 : mem[rd_idx];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       push = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       pop = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] rdata;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       ovf;
   logic       unf;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] q [$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   uart_rx_fifo #(.DW(8), .DEPTH(16), .AW(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (push),
      .i_wdata     (wdata),
      .i_pop       (pop),
      .o_rdata     (rdata),
      .o_empty     (empty),
      .o_full      (full),
      .o_count     (count),
      .o_overflow  (ovf),
      .i_clr_ovf   (clr),
      .o_underflow (unf)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       push;
      logic [7:0] wdata;
      logic       pop;
      logic       clr;
      int         gap;
      int         exp_count;
      logic       exp_empty;
      logic       exp_full;
      logic [7:0] exp_rdata;
      logic       exp_ovf;
      logic       exp_unf;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_update(input logic p, input logic [7:0] d,
                                        input logic po, input logic c);
      bit m_empty = (q.size() == 0);
      bit m_full  = (q.size() == 16);
      bit pop_ok  = po && !m_empty;
      bit push_ok = p && (!m_full || pop_ok);
      m_unf = po && m_empty;
      if (p && m_full && !pop_ok) m_ovf = 1'b1;
      else if (c)                 m_ovf = 1'b0;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(d);
   endfunction

   task automatic cmp_model(input string tag);
      chk({tag, ".count"}, int'(count), q.size());
      chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
      chk({tag, ".full"},  int'(full),  int'(q.size() == 16));
      chk({tag, ".rdata"}, int'(rdata), (q.size() == 0) ? 0 : int'(q[0]));
      chk({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
      chk({tag, ".unf"},   int'(unf),   int'(m_unf));
   endtask

   // Drive one cycle, advance model at the edge, compare #1 after it.
   task automatic step(input logic p, input logic [7:0] d, input logic po,
                       input logic c, input string tag);
      push = p; wdata = d; pop = po; clr = c;
      @(posedge clk);
      model_update(p, d, po, c);
      #1;
      push = 1'b0; pop = 1'b0; clr = 1'b0;
      cmp_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0, "fill");
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst.empty", int'(empty), 1);
      chk("rst.full",  int'(full), 0);
      chk("rst.count", int'(count), 0);
      chk("rst.rdata", int'(rdata), 0);
      chk("rst.ovf",   int'(ovf), 0);
      chk("rst.unf",   int'(unf), 0);

      // Vector table: basic push/pop order and empty-FIFO corners
      vt[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 10, 1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 10, 2, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 10, 3, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0,  2, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0,  1, 1'b0, 1'b0, 8'h43, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 8'h7E, 1'b1, 1'b0, 0,  1, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0,  1, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0};
      vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0,  1, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0,  0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         step(vt[i].push, vt[i].wdata, vt[i].pop, vt[i].clr, "vec");
         chk($sformatf("vec%0d.count", i), int'(count), vt[i].exp_count);
         chk($sformatf("vec%0d.empty", i), int'(empty), int'(vt[i].exp_empty));
         chk($sformatf("vec%0d.full", i),  int'(full),  int'(vt[i].exp_full));
         chk($sformatf("vec%0d.rdata", i), int'(rdata), int'(vt[i].exp_rdata));
         chk($sformatf("vec%0d.ovf", i),   int'(ovf),   int'(vt[i].exp_ovf));
         chk($sformatf("vec%0d.unf", i),   int'(unf),   int'(vt[i].exp_unf));
         for (int g = 0; g < vt[i].gap; g++) step(1'b0, 8'h00, 1'b0, 1'b0, "gap");
      end

      // Fill to full, overflow drops 0xAA, drain in order
      do_reset();
      fill(8'h00, 16);
      chk("full.full", int'(full), 1);
      chk("full.count", int'(count), 16);
      step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
      chk("ovf.set", int'(ovf), 1);
      chk("ovf.count", int'(count), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d", i), int'(rdata), i);
         step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      end
      chk("drain.empty", int'(empty), 1);
      chk("ovf.sticky", int'(ovf), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
      chk("ovf.clr", int'(ovf), 0);

      // Clear coinciding with a new overflow: set wins
      fill(8'h10, 16);
      step(1'b1, 8'hBB, 1'b0, 1'b1, "setwin");
      chk("ovf.setwins", int'(ovf), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1, "clr2");
      chk("ovf.clr2", int'(ovf), 0);

      // Full FIFO with simultaneous push and pop
      step(1'b1, 8'h55, 1'b1, 1'b0, "fullpp");
      chk("fullpp.ovf", int'(ovf), 0);
      chk("fullpp.count", int'(count), 16);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "pp_drain");
      chk("fullpp.16th", int'(rdata), 8'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0, "pp_last");
      chk("fullpp.empty", int'(empty), 1);

      // Reset mid-pop with overflow set discards everything at once
      fill(8'h20, 16);
      step(1'b1, 8'hCC, 1'b0, 1'b0, "ovf3");
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "to5");
      chk("mid.count5", int'(count), 5);
      chk("mid.ovf1", int'(ovf), 1);
      pop = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.empty", int'(empty), 1);
      chk("arst.count", int'(count), 0);
      chk("arst.ovf", int'(ovf), 0);
      chk("arst.rdata", int'(rdata), 0);
      pop = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(1'b1, 8'h31, 1'b0, 1'b0, "post_rst");
      chk("post_rst.rdata", int'(rdata), 8'h31);
      chk("post_rst.count", int'(count), 1);

      // Random traffic against the model; pointers wrap many times
      do_reset();
      for (int i = 0; i < 800; i++) begin
         logic       p, po, c;
         logic [7:0] d;
         int         bias;
         bias = ((i / 100) % 2 == 0) ? 60 : 40;
         p  = ($urandom_range(0, 99) < bias);
         po = ($urandom_range(0, 99) < 50);
         c  = ($urandom_range(0, 15) == 0);
         d  = 8'($urandom);
         step(p, d, po, c, "rnd");
         if (count > 5'd16) chk("rnd.count_bound", int'(count), 16);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
